// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: merges load-use stall, taken-branch flush and
// data-cache miss freeze into stage-register enables, plus stall/miss counters.
module hazard_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_RegRt_i,
    input  logic [4:0]  IFID_RegRs_i,
    input  logic [4:0]  IFID_RegRt_i,
    input  logic        Branch_i,
    input  logic        DCacheReq_i,
    input  logic        DCacheReady_i,
    output logic        PCWrite_o,
    output logic        IFIDWrite_o,
    output logic        IFIDFlush_o,
    output logic        IDEXWrite_o,
    output logic        IDEXBubble_o,
    output logic        EXMEMWrite_o,
    output logic        MEMWBWrite_o,
    output logic [15:0] StallCnt_o,
    output logic [7:0]  MissCnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_MISS_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        w_loadUse;
    logic        w_unfrozen;
    logic        w_missStart;
    logic        w_stallEvent;
    logic [15:0] r_stallCnt;
    logic [7:0]  r_missCnt;

    assign w_loadUse = IDEX_MemRead_i && (IDEX_RegRt_i != 5'd0) &&
                       ((IDEX_RegRt_i == IFID_RegRs_i) || (IDEX_RegRt_i == IFID_RegRt_i));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Frozen cycles leave every enable at its zero default; only unfrozen
    // cycles in RUN or the miss release cycle see the hazard/flush rules.
    always_comb begin
        w_nextState  = r_state;
        w_unfrozen   = 1'b0;
        w_missStart  = 1'b0;
        PCWrite_o    = 1'b0;
        IFIDWrite_o  = 1'b0;
        IFIDFlush_o  = 1'b0;
        IDEXWrite_o  = 1'b0;
        IDEXBubble_o = 1'b0;
        EXMEMWrite_o = 1'b0;
        MEMWBWrite_o = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                if (DCacheReq_i && !DCacheReady_i) begin
                    w_nextState = S_MISS_WAIT;
                    w_missStart = 1'b1;
                end else begin
                    w_unfrozen = 1'b1;
                end
            end
            S_MISS_WAIT: begin
                if (DCacheReady_i) begin
                    w_nextState = S_RUN;
                    w_unfrozen  = 1'b1;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase

        if (w_unfrozen) begin
            PCWrite_o    = 1'b1;
            IFIDWrite_o  = 1'b1;
            IDEXWrite_o  = 1'b1;
            EXMEMWrite_o = 1'b1;
            MEMWBWrite_o = 1'b1;
            // A load-use bubble wins over flush; the branch re-resolves next cycle.
            if (w_loadUse) begin
                PCWrite_o    = 1'b0;
                IFIDWrite_o  = 1'b0;
                IDEXBubble_o = 1'b1;
            end else if (Branch_i) begin
                IFIDFlush_o = 1'b1;
            end
        end
    end

    assign w_stallEvent = (r_state != S_IDLE) && !PCWrite_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stallCnt <= 16'd0;
            r_missCnt  <= 8'd0;
        end else begin
            if (w_stallEvent && (r_stallCnt != 16'hFFFF)) begin
                r_stallCnt <= r_stallCnt + 16'd1;
            end
            if (w_missStart && (r_missCnt != 8'hFF)) begin
                r_missCnt <= r_missCnt + 8'd1;
            end
        end
    end

    assign StallCnt_o = r_stallCnt;
    assign MissCnt_o  = r_missCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the sequencing rules.
module tb_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        IDEX_MemRead_i;
    logic [4:0]  IDEX_RegRt_i;
    logic [4:0]  IFID_RegRs_i;
    logic [4:0]  IFID_RegRt_i;
    logic        Branch_i;
    logic        DCacheReq_i;
    logic        DCacheReady_i;
    logic        PCWrite_o;
    logic        IFIDWrite_o;
    logic        IFIDFlush_o;
    logic        IDEXWrite_o;
    logic        IDEXBubble_o;
    logic        EXMEMWrite_o;
    logic        MEMWBWrite_o;
    logic [15:0] StallCnt_o;
    logic [7:0]  MissCnt_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: "active" means the core has been started, "missOpen"
    // means a cache access is still outstanding from an earlier cycle.
    bit active;
    bit missOpen;
    int stallModel;
    int missModel;
    bit expFreeze;
    bit expPc;

    hazard_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .IDEX_MemRead_i (IDEX_MemRead_i),
        .IDEX_RegRt_i   (IDEX_RegRt_i),
        .IFID_RegRs_i   (IFID_RegRs_i),
        .IFID_RegRt_i   (IFID_RegRt_i),
        .Branch_i       (Branch_i),
        .DCacheReq_i    (DCacheReq_i),
        .DCacheReady_i  (DCacheReady_i),
        .PCWrite_o      (PCWrite_o),
        .IFIDWrite_o    (IFIDWrite_o),
        .IFIDFlush_o    (IFIDFlush_o),
        .IDEXWrite_o    (IDEXWrite_o),
        .IDEXBubble_o   (IDEXBubble_o),
        .EXMEMWrite_o   (EXMEMWrite_o),
        .MEMWBWrite_o   (MEMWBWrite_o),
        .StallCnt_o     (StallCnt_o),
        .MissCnt_o      (MissCnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic applyStimulus(input bit st, input bit mr, input int ldRt, input int rs,
                                 input int rt, input bit br, input bit req, input bit rdy);
        start_i        = st;
        IDEX_MemRead_i = mr;
        IDEX_RegRt_i   = 5'(ldRt);
        IFID_RegRs_i   = 5'(rs);
        IFID_RegRt_i   = 5'(rt);
        Branch_i       = br;
        DCacheReq_i    = req;
        DCacheReady_i  = rdy;
    endtask

    task automatic compare(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        active     = 0;
        missOpen   = 0;
        stallModel = 0;
        missModel  = 0;
    endtask

    task automatic checkOutput();
        bit hazard;
        bit flush;
        bit flowing;
        expFreeze = active && !DCacheReady_i && (missOpen || DCacheReq_i);
        flowing   = active && !expFreeze;
        hazard    = flowing && IDEX_MemRead_i && (IDEX_RegRt_i != 0) &&
                    ((IDEX_RegRt_i == IFID_RegRs_i) || (IDEX_RegRt_i == IFID_RegRt_i));
        flush     = flowing && !hazard && Branch_i;
        expPc     = flowing && !hazard;
        compare("PCWrite",    int'(PCWrite_o),    int'(expPc));
        compare("IFIDWrite",  int'(IFIDWrite_o),  int'(expPc));
        compare("IFIDFlush",  int'(IFIDFlush_o),  int'(flush));
        compare("IDEXWrite",  int'(IDEXWrite_o),  int'(flowing));
        compare("IDEXBubble", int'(IDEXBubble_o), int'(hazard));
        compare("EXMEMWrite", int'(EXMEMWrite_o), int'(flowing));
        compare("MEMWBWrite", int'(MEMWBWrite_o), int'(flowing));
        compare("StallCnt",   int'(StallCnt_o),   stallModel);
        compare("MissCnt",    int'(MissCnt_o),    missModel);
    endtask

    // One clock: check combinational outputs mid-cycle, then advance the model.
    task automatic cycle();
        bit wasActive;
        #3;
        checkOutput();
        @(posedge clk_i);
        wasActive = active;
        if (rst_i) begin
            resetModel();
        end else if (!wasActive) begin
            active = start_i;
        end else begin
            if (!expPc && stallModel < 65535) stallModel++;
            if (expFreeze && !missOpen && missModel < 255) missModel++;
            missOpen = expFreeze;
        end
        #1;
    endtask

    initial begin
        resetModel();
        rst_i = 1'b1;
        applyStimulus(1, 1, 8, 8, 8, 1, 1, 0);
        cycle();
        cycle();

        // Start sequence: IDLE ignores everything except start.
        rst_i = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();

        // Load-use on rt, then on rs, then register zero which must not stall.
        applyStimulus(0, 1, 8, 3, 8, 0, 0, 0);
        cycle();
        applyStimulus(0, 1, 9, 9, 4, 0, 0, 0);
        cycle();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        applyStimulus(0, 0, 8, 8, 8, 0, 0, 0);
        cycle();

        // Branch under a load-use hazard, then a clean branch.
        applyStimulus(0, 1, 5, 5, 1, 1, 0, 0);
        cycle();
        applyStimulus(0, 0, 5, 5, 1, 1, 0, 0);
        cycle();

        // Four frozen cycles then release; hazard and branch held during freeze.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        applyStimulus(0, 1, 7, 7, 7, 1, 1, 0);
        cycle();
        cycle();
        cycle();
        applyStimulus(0, 1, 7, 7, 7, 1, 1, 1);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Hit, then back-to-back misses with a new request right after release.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        cycle();

        // Random traffic with a small register pool so hazards are common.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 1), ($urandom_range(0, 2) == 0),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 2) != 0));
            cycle();
        end

        // Drive enough misses to saturate the miss counter.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
            cycle();
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
            cycle();
        end
        compare("MissCntSat", int'(MissCnt_o), 255);

        // Asynchronous reset in the middle of a miss wait.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        cycle();
        rst_i = 1'b1;
        #1;
        resetModel();
        checkOutput();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        cycle();
        rst_i = 1'b0;
        cycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
